// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HOLD     = 2'd3
    } kp_state_t;

    localparam int KP_NUM_COLS = 4;
    localparam int KP_NUM_ROWS = 4;
    localparam int KP_CODE_W   = 4;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-report bundle; the controller is the slave side.
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic                   en;
    logic [KP_NUM_ROWS-1:0] row_i;
    logic [KP_NUM_COLS-1:0] col_o;
    logic [KP_CODE_W-1:0]   key_code;
    logic                   key_valid;
    logic                   key_held;

    modport master (
        output en, row_i,
        input  col_o, key_code, key_valid, key_held
    );

    modport slave (
        input  en, row_i,
        output col_o, key_code, key_valid, key_held
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates column drive, debounces press and release of
// the first key found, and strobes its {col,row} code once per accepted press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_scan_ctrl_if.slave    kp
);

    localparam int DW  = $clog2(SCAN_CYCLES) + 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_TERM   = DBW'(DEBOUNCE_CYCLES);

    kp_state_t              state_reg, state_next;
    logic [1:0]             col_idx_reg, col_idx_next;
    logic [1:0]             row_idx_reg, row_idx_next;
    logic [KP_NUM_ROWS-1:0] row_oh_reg, row_oh_next;
    logic [DW-1:0]          dwell_cnt_reg, dwell_cnt_next;
    logic [DBW-1:0]         deb_cnt_reg, deb_cnt_next;
    logic [DBW-1:0]         rel_cnt_reg, rel_cnt_next;
    logic [KP_CODE_W-1:0]   key_code_reg, key_code_next;
    logic [KP_NUM_ROWS-1:0] row_s;
    logic [1:0]             row_first;
    logic [DBW-1:0]         deb_inc, rel_inc;
    logic                   drive_on;

    sync_2ff #(.WIDTH(KP_NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.row_i),
        .q   (row_s)
    );

    // Lowest set row wins when several rows are seen in the same sample.
    function automatic logic [1:0] lowest_row(input logic [KP_NUM_ROWS-1:0] r);
        lowest_row = 2'd0;
        for (int i = KP_NUM_ROWS - 1; i >= 0; i--) begin
            if (r[i]) lowest_row = 2'(i);
        end
    endfunction

    assign row_first = lowest_row(row_s);
    assign deb_inc   = deb_cnt_reg + DBW'(1);
    assign rel_inc   = rel_cnt_reg + DBW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= SCAN;
            col_idx_reg   <= '0;
            row_idx_reg   <= '0;
            row_oh_reg    <= '0;
            dwell_cnt_reg <= '0;
            deb_cnt_reg   <= '0;
            rel_cnt_reg   <= '0;
            key_code_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            row_idx_reg   <= row_idx_next;
            row_oh_reg    <= row_oh_next;
            dwell_cnt_reg <= dwell_cnt_next;
            deb_cnt_reg   <= deb_cnt_next;
            rel_cnt_reg   <= rel_cnt_next;
            key_code_reg  <= key_code_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        row_idx_next   = row_idx_reg;
        row_oh_next    = row_oh_reg;
        dwell_cnt_next = dwell_cnt_reg;
        deb_cnt_next   = deb_cnt_reg;
        rel_cnt_next   = rel_cnt_reg;
        key_code_next  = key_code_reg;

        if (!kp.en) begin
            state_next     = SCAN;
            col_idx_next   = '0;
            dwell_cnt_next = '0;
            deb_cnt_next   = '0;
            rel_cnt_next   = '0;
        end else begin
            unique case (state_reg)
                SCAN: begin
                    if (dwell_cnt_reg == DWELL_LAST) begin
                        dwell_cnt_next = '0;
                        if (row_s != '0) begin
                            row_idx_next = row_first;
                            row_oh_next  = KP_NUM_ROWS'(1) << row_first;
                            deb_cnt_next = '0;
                            state_next   = DEBOUNCE;
                        end else begin
                            col_idx_next = col_idx_reg + 2'd1;
                        end
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    // Only the exact latched row counts; extra rows abort the press.
                    if (row_s == row_oh_reg) begin
                        if (deb_inc == DEB_TERM) begin
                            deb_cnt_next  = '0;
                            key_code_next = {col_idx_reg, row_idx_reg};
                            state_next    = PRESSED;
                        end else begin
                            deb_cnt_next = deb_inc;
                        end
                    end else begin
                        deb_cnt_next   = '0;
                        col_idx_next   = col_idx_reg + 2'd1;
                        dwell_cnt_next = '0;
                        state_next     = SCAN;
                    end
                end
                PRESSED: begin
                    rel_cnt_next = '0;
                    state_next   = HOLD;
                end
                HOLD: begin
                    if (row_s == '0) begin
                        if (rel_inc == DEB_TERM) begin
                            rel_cnt_next   = '0;
                            col_idx_next   = col_idx_reg + 2'd1;
                            dwell_cnt_next = '0;
                            state_next     = SCAN;
                        end else begin
                            rel_cnt_next = rel_inc;
                        end
                    end else begin
                        rel_cnt_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // Column 0 is shown during reset even if the scan is disabled.
    assign drive_on = kp.en || !rst;

    for (genvar gi = 0; gi < KP_NUM_COLS; gi++) begin : g_col
        assign kp.col_o[gi] = drive_on && (col_idx_reg == 2'(gi));
    end

    always_comb begin
        kp.key_valid = (state_reg == PRESSED);
        kp.key_held  = (state_reg == HOLD) && kp.en;
        kp.key_code  = key_code_reg;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a keypad matrix model and a
// scoreboard of expected key codes.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int SC = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          strobe_cnt = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    logic [3:0]  pressed [4];
    logic        force_en;
    logic [3:0]  force_val;
    logic [3:0]  kc_before;

    // Keypad matrix: a closed key connects its row to its column drive.
    always_comb begin
        logic [3:0] r;
        r = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (kif.col_o[c]) r = r | pressed[c];
        end
        if (force_en) r = force_val;
        kif.row_i = r;
    end

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            got_q.push_back(kif.key_code);
            strobe_cnt++;
            $display("strobe: key_code=%b at %0t", kif.key_code, $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] c, input int budget, input string tag);
        int k = 0;
        while (kif.col_o !== c && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(kif.col_o === c), 32'd1);
    endtask

    task automatic wait_held(input logic v, input int budget, input string tag);
        int k = 0;
        while (kif.key_held !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(kif.key_held === v), 32'd1);
    endtask

    task automatic check_pop(input string tag);
        logic [3:0] e, g;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        g = (got_q.size() > 0) ? got_q.pop_front() : 4'bzzzz;
        $display("scoreboard %s: got=%b exp=%b", tag, g, e);
        check(tag, 32'(g), 32'(e));
    endtask

    initial begin
        rst       = 1'b0;
        kif.en    = 1'b1;
        force_en  = 1'b0;
        force_val = 4'b0000;
        for (int c = 0; c < 4; c++) pressed[c] = 4'b0000;

        #1;
        check("reset_col", 32'(kif.col_o), 32'b0001);
        check("reset_code", 32'(kif.key_code), 32'h0);
        check("reset_valid", 32'(kif.key_valid), 32'h0);
        check("reset_held", 32'(kif.key_held), 32'h0);

        // 1: rotation
        tick(2);
        rst = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            check($sformatf("rot%0d", i), 32'(kif.col_o), 32'(4'b0001 << ((i / 4) % 4)));
            tick(1);
        end
        check("rot_no_strobe", 32'(strobe_cnt), 32'd0);

        // 2: clean press col1,row2
        pressed[1] = 4'b0100;
        exp_q.push_back(4'b0110);
        wait_held(1'b1, 60, "press_held_rise");
        check_pop("press_code");
        check("press_code_out", 32'(kif.key_code), 32'b0110);
        check("press_col_hold", 32'(kif.col_o), 32'b0010);
        pressed[1] = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("release_held%0d", k), 32'(kif.key_held), 32'd1);
            tick(1);
        end
        check("release_held_fall", 32'(kif.key_held), 32'd0);
        check("release_next_col", 32'(kif.col_o), 32'b0100);
        check("press_one_strobe", 32'(strobe_cnt), 32'd1);

        // 3: bounce on col0,row1
        wait_col(4'b1000, 40, "bounce_wait_c3");
        wait_col(4'b0001, 20, "bounce_wait_c0");
        kc_before = kif.key_code;
        tick(1);
        force_en  = 1'b1;
        force_val = 4'b0010;
        tick(2);
        force_val = 4'b0000;
        tick(1);
        check("bounce_col_held", 32'(kif.col_o), 32'b0001);
        tick(2);
        check("bounce_next_col", 32'(kif.col_o), 32'b0010);
        check("bounce_code_kept", 32'(kif.key_code), 32'(kc_before));
        check("bounce_no_strobe", 32'(strobe_cnt), 32'd1);
        force_en = 1'b0;

        // 4: rows 0 and 3 in the col3 detection sample, row 0 stays down
        wait_col(4'b1000, 40, "multi_wait_c3");
        exp_q.push_back(4'b1100);
        tick(1);
        force_en  = 1'b1;
        force_val = 4'b1001;
        tick(1);
        force_val = 4'b0001;
        wait_held(1'b1, 20, "multi_held_rise");
        check_pop("multi_code");
        check("multi_col_hold", 32'(kif.col_o), 32'b1000);
        force_val = 4'b0000;
        wait_held(1'b0, 20, "multi_held_fall");
        force_en = 1'b0;
        check("multi_next_col", 32'(kif.col_o), 32'b0001);
        check("multi_one_strobe", 32'(strobe_cnt), 32'd2);

        // 6: enable drop mid-dwell on col2
        wait_col(4'b0100, 40, "en_wait_c2");
        tick(2);
        kif.en = 1'b0;
        #1;
        check("en_low_col", 32'(kif.col_o), 32'b0000);
        check("en_low_held", 32'(kif.key_held), 32'd0);
        tick(2);
        check("en_low_col_later", 32'(kif.col_o), 32'b0000);
        kif.en = 1'b1;
        #1;
        for (int i = 0; i <= 4; i++) begin
            check($sformatf("en_restart%0d", i), 32'(kif.col_o), 32'(4'b0001 << (i / 4)));
            @(negedge clk);
        end
        check("en_code_kept", 32'(kif.key_code), 32'b1100);

        // 5: reset during HOLD
        pressed[2] = 4'b0001;
        exp_q.push_back(4'b1000);
        wait_held(1'b1, 60, "rsthold_held_rise");
        check_pop("rsthold_code");
        #2;
        rst = 1'b0;
        #1;
        check("rsthold_col", 32'(kif.col_o), 32'b0001);
        check("rsthold_code_clr", 32'(kif.key_code), 32'h0);
        check("rsthold_held", 32'(kif.key_held), 32'd0);
        check("rsthold_valid", 32'(kif.key_valid), 32'd0);
        pressed[2] = 4'b0000;
        tick(2);
        rst = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            check($sformatf("rsthold_rot%0d", i), 32'(kif.col_o), 32'(4'b0001 << (i / 4)));
            tick(1);
        end
        check("total_strobes", 32'(strobe_cnt), 32'd3);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("got_q_empty", 32'(got_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
